inst_fetch_port: RTL and testbench

- Fetch-side responder for the PC stage: takes the fetch address, enable and instruction-side exceptions from the PC.
- Runs a single-outstanding request/response transaction on the instruction bus.
- Delivers the instruction, its PC and its exception vector to the decode stage.
- Back-pressures the PC with `if_stall` until each fetch completes; discards responses killed by a flush.

---
 rtl/inst_fetch_port_pkg.sv | 35 +++
 rtl/inst_fetch_port_if.sv | 15 +
 rtl/inst_fetch_port_if_hold_buf.sv | 38 +++
 rtl/inst_fetch_port.sv | 217 +++++++++++++++++++++
 tb/tb_inst_fetch_port.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_port_pkg.sv
// Shared types and constants for the instruction fetch port.
// Bus widths, exception indices, FSM state encoding and the NOP word
// delivered with exception-only fetches.
package inst_fetch_port_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int EXC_W  = 3;

   // Instruction-side exception bit positions
   localparam int Exc_I_AdE  = 0;
   localparam int Exc_I_TLBR = 1;
   localparam int Exc_I_TLBI = 2;

   typedef logic [ADDR_W-1:0] addr_bus_t;
   typedef logic [DATA_W-1:0] data_bus_t;
   typedef logic [EXC_W-1:0]  exc_bus_t;

   localparam data_bus_t NOP_INST = 32'h0000_0000;

   typedef enum logic [2:0] {
      IF_IDLE      = 3'd0,
      IF_REQ       = 3'd1,
      IF_WAIT      = 3'd2,
      IF_KILL_REQ  = 3'd3,
      IF_KILL_WAIT = 3'd4,
      IF_HOLD      = 3'd5
   } if_state_e;

   // True when any instruction-side exception is flagged for the fetch
   function automatic logic exc_any(input exc_bus_t excp);
      return |excp;
   endfunction

endpackage

// File: rtl/inst_fetch_port_if.sv
// Instruction bus: single-outstanding request/ack, then rvalid/rdata.
// The fetch port is the master; the memory side is the slave.
interface inst_fetch_port_if;
   import inst_fetch_port_pkg::*;

   logic      req;
   addr_bus_t addr;
   logic      ack;
   logic      rvalid;
   data_bus_t rdata;

   modport master (output req, output addr, input ack, input rvalid, input rdata);
   modport slave  (input req, input addr, output ack, output rvalid, output rdata);

endinterface

// File: rtl/inst_fetch_port_if_hold_buf.sv
// One-entry buffer that parks a fetched instruction while decode is
// stalled. Only compiled when IF_HOLD_BUF_EN is defined.
`ifdef IF_HOLD_BUF_EN
module if_hold_buf
   import inst_fetch_port_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  logic      clear,
   input  data_bus_t wr_data,
   input  addr_bus_t wr_pc,
   input  exc_bus_t  wr_excp,
   output data_bus_t rd_data,
   output addr_bus_t rd_pc,
   output exc_bus_t  rd_excp,
   output logic      full
);

   // Capture the entry on load; clear only drops the full flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= {DATA_W{1'b0}};
         rd_pc   <= {ADDR_W{1'b0}};
         rd_excp <= {EXC_W{1'b0}};
         full    <= 1'b0;
      end else if (clear) begin
         full    <= 1'b0;
      end else if (load) begin
         rd_data <= wr_data;
         rd_pc   <= wr_pc;
         rd_excp <= wr_excp;
         full    <= 1'b1;
      end
   end

endmodule
`endif

// File: rtl/inst_fetch_port.sv
// Fetch-side responder between the PC stage and decode.
// Issues one outstanding instruction-bus read at a time, delivers the
// instruction with its PC and exceptions, stalls the PC until the
// fetch completes and discards responses killed by a flush.
// Optional feature macro: IF_HOLD_BUF_EN (one-entry buffer for data
// returning while decode is stalled).
module inst_fetch_port
   import inst_fetch_port_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  addr_bus_t                pc,
   input  logic                     i_en,
   input  exc_bus_t                 excp_in,
   input  logic                     flush,
   input  logic                     stall_in,
   inst_fetch_port_if.master        ibus,
   output logic                     if_stall,
   output data_bus_t                inst,
   output addr_bus_t                inst_pc,
   output exc_bus_t                 inst_excp,
   output logic                     inst_valid
);

   if_state_e state_r;
   if_state_e state_nxt_s;
   addr_bus_t addr_q_r;

   logic      fetch_ok_s;
   logic      req_s;
   addr_bus_t req_addr_s;
   logic      latch_addr_s;
   logic      deliver_s;
   logic      out_load_s;
   data_bus_t out_inst_s;
   addr_bus_t out_pc_s;
   exc_bus_t  out_excp_s;

`ifdef IF_HOLD_BUF_EN
   logic      hbuf_load_s;
   logic      hbuf_clear_s;
   data_bus_t hbuf_data_s;
   addr_bus_t hbuf_pc_s;
   exc_bus_t  hbuf_excp_s;
   logic      hbuf_full_s;

   if_hold_buf u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .load    (hbuf_load_s),
      .clear   (hbuf_clear_s),
      .wr_data (ibus.rdata),
      .wr_pc   (addr_q_r),
      .wr_excp ({EXC_W{1'b0}}),
      .rd_data (hbuf_data_s),
      .rd_pc   (hbuf_pc_s),
      .rd_excp (hbuf_excp_s),
      .full    (hbuf_full_s)
   );
`endif

   assign fetch_ok_s = i_en & ~flush & ~stall_in;

   // Next-state, bus request and delivery decode
   always_comb begin
      state_nxt_s  = state_r;
      req_s        = 1'b0;
      req_addr_s   = addr_q_r;
      latch_addr_s = 1'b0;
      deliver_s    = 1'b0;
      out_load_s   = 1'b0;
      out_inst_s   = NOP_INST;
      out_pc_s     = pc;
      out_excp_s   = {EXC_W{1'b0}};
`ifdef IF_HOLD_BUF_EN
      hbuf_load_s  = 1'b0;
      hbuf_clear_s = 1'b0;
`endif
      case (state_r)
         IF_IDLE: begin
            if (fetch_ok_s) begin
               if (exc_any(excp_in)) begin
                  // Faulting fetch never touches the bus
                  deliver_s   = 1'b1;
                  out_load_s  = 1'b1;
                  out_excp_s  = excp_in;
                  state_nxt_s = IF_IDLE;
               end else begin
                  req_s        = 1'b1;
                  req_addr_s   = pc;
                  latch_addr_s = 1'b1;
                  if (ibus.ack) begin
                     state_nxt_s = IF_WAIT;
                  end else begin
                     state_nxt_s = IF_REQ;
                  end
               end
            end else begin
               state_nxt_s = IF_IDLE;
            end
         end
         IF_REQ: begin
            // Request stays up until accepted, even across a flush
            req_s = 1'b1;
            if (ibus.ack) begin
               state_nxt_s = flush ? IF_KILL_WAIT : IF_WAIT;
            end else if (flush) begin
               state_nxt_s = IF_KILL_REQ;
            end else begin
               state_nxt_s = IF_REQ;
            end
         end
         IF_WAIT: begin
            if (ibus.rvalid) begin
               state_nxt_s = IF_IDLE;
               if (flush) begin
                  state_nxt_s = IF_IDLE;
               end else if (!stall_in) begin
                  deliver_s  = 1'b1;
                  out_load_s = 1'b1;
                  out_inst_s = ibus.rdata;
                  out_pc_s   = addr_q_r;
               end else begin
`ifdef IF_HOLD_BUF_EN
                  // Park the word so the PC can move on
                  hbuf_load_s = 1'b1;
                  deliver_s   = 1'b1;
                  state_nxt_s = IF_HOLD;
`else
                  // Data dropped; same pc is fetched again after the stall
                  state_nxt_s = IF_IDLE;
`endif
               end
            end else if (flush) begin
               state_nxt_s = IF_KILL_WAIT;
            end else begin
               state_nxt_s = IF_WAIT;
            end
         end
         IF_KILL_REQ: begin
            req_s = 1'b1;
            if (ibus.ack) begin
               state_nxt_s = IF_KILL_WAIT;
            end else begin
               state_nxt_s = IF_KILL_REQ;
            end
         end
         IF_KILL_WAIT: begin
            if (ibus.rvalid) begin
               state_nxt_s = IF_IDLE;
            end else begin
               state_nxt_s = IF_KILL_WAIT;
            end
         end
`ifdef IF_HOLD_BUF_EN
         IF_HOLD: begin
            if (flush) begin
               hbuf_clear_s = 1'b1;
               state_nxt_s  = IF_IDLE;
            end else if (!stall_in) begin
               out_load_s   = hbuf_full_s;
               out_inst_s   = hbuf_data_s;
               out_pc_s     = hbuf_pc_s;
               out_excp_s   = hbuf_excp_s;
               hbuf_clear_s = 1'b1;
               state_nxt_s  = IF_IDLE;
            end else begin
               state_nxt_s = IF_HOLD;
            end
         end
`endif
         default: begin
            state_nxt_s = IF_IDLE;
         end
      endcase
   end

   assign ibus.req  = req_s & rst;
   assign ibus.addr = req_addr_s;
   assign if_stall  = i_en & ~flush & ~deliver_s;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IF_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Address of the outstanding request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q_r <= {ADDR_W{1'b0}};
      end else if (latch_addr_s) begin
         addr_q_r <= pc;
      end
   end

   // Decode-side outputs: load on delivery, hold while decode stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst       <= {DATA_W{1'b0}};
         inst_pc    <= {ADDR_W{1'b0}};
         inst_excp  <= {EXC_W{1'b0}};
         inst_valid <= 1'b0;
      end else if (out_load_s) begin
         inst       <= out_inst_s;
         inst_pc    <= out_pc_s;
         inst_excp  <= out_excp_s;
         inst_valid <= 1'b1;
      end else if (flush || !stall_in) begin
         inst_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Directed self-checking bench for inst_fetch_port.
// The stalled-response scenario checks the buffered behaviour when
// IF_HOLD_BUF_EN is defined and the re-fetch behaviour otherwise.
module tb_inst_fetch_port;
   import inst_fetch_port_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   addr_bus_t pc;
   logic      i_en;
   exc_bus_t  excp_in;
   logic      flush;
   logic      stall_in;
   logic      if_stall;
   data_bus_t inst;
   addr_bus_t inst_pc;
   exc_bus_t  inst_excp;
   logic      inst_valid;

   int err_cnt = 0;
   int chk_cnt = 0;

   inst_fetch_port_if ibus_if ();

   inst_fetch_port dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .i_en       (i_en),
      .excp_in    (excp_in),
      .flush      (flush),
      .stall_in   (stall_in),
      .ibus       (ibus_if.master),
      .if_stall   (if_stall),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_excp  (inst_excp),
      .inst_valid (inst_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b0; pc = 32'h0; i_en = 1'b0; excp_in = 3'b000;
      flush = 1'b0; stall_in = 1'b0;
      ibus_if.ack = 1'b0; ibus_if.rvalid = 1'b0; ibus_if.rdata = 32'h0;
      tick(); tick();

      // Reset state
      check("rst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_excp", inst_excp, 3'b000);
      check("rst_req", ibus_if.req, 1'b0);
      check("rst_stall", if_stall, 1'b0);
      i_en = 1'b1; pc = 32'hBFC0_0000; settle();
      check("rst_req_forced", ibus_if.req, 1'b0);
      tick();

      // Best-case fetch out of reset
      rst = 1'b1; ibus_if.ack = 1'b1; settle();
      check("t1_req", ibus_if.req, 1'b1);
      check("t1_addr", ibus_if.addr, 32'hBFC0_0000);
      check("t1_stall_c0", if_stall, 1'b1);
      tick();
      ibus_if.ack = 1'b0; ibus_if.rvalid = 1'b1; ibus_if.rdata = 32'h2408_0001; settle();
      check("t1_stall_c1", if_stall, 1'b0);
      check("t1_req_c1", ibus_if.req, 1'b0);
      tick();
      ibus_if.rvalid = 1'b0; i_en = 1'b0; settle();
      check("t1_valid", inst_valid, 1'b1);
      check("t1_inst", inst, 32'h2408_0001);
      check("t1_inst_pc", inst_pc, 32'hBFC0_0000);
      check("t1_excp", inst_excp, 3'b000);
      tick();
      check("t1_valid_clr", inst_valid, 1'b0);

      // Exception-only fetch
      pc = 32'h0000_0002; excp_in = 3'b001; i_en = 1'b1; settle();
      check("t2_req", ibus_if.req, 1'b0);
      check("t2_stall", if_stall, 1'b0);
      tick();
      i_en = 1'b0; excp_in = 3'b000; settle();
      check("t2_valid", inst_valid, 1'b1);
      check("t2_inst", inst, 32'h0);
      check("t2_inst_pc", inst_pc, 32'h0000_0002);
      check("t2_ade", inst_excp[Exc_I_AdE], 1'b1);
      tick();

      // Flush while the request is pending
      pc = 32'h0000_0100; i_en = 1'b1; settle();
      check("t3_req_idle", ibus_if.req, 1'b1);
      tick();
      flush = 1'b1; settle();
      check("t3_req_flush", ibus_if.req, 1'b1);
      check("t3_stall_flush", if_stall, 1'b0);
      tick();
      flush = 1'b0; pc = 32'h0000_0200;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("t3_kreq_req", ibus_if.req, 1'b1);
         check("t3_kreq_addr", ibus_if.addr, 32'h0000_0100);
         check("t3_kreq_stall", if_stall, 1'b1);
         tick();
      end
      ibus_if.ack = 1'b1; settle();
      check("t3_ack_addr", ibus_if.addr, 32'h0000_0100);
      tick();
      ibus_if.ack = 1'b0; settle();
      check("t3_kwait_req", ibus_if.req, 1'b0);
      tick();
      ibus_if.rvalid = 1'b1; ibus_if.rdata = 32'hDEAD_BEEF; settle();
      check("t3_kwait_stall", if_stall, 1'b1);
      tick();
      ibus_if.rvalid = 1'b0; settle();
      check("t3_dropped", inst_valid, 1'b0);
      check("t3_new_req", ibus_if.req, 1'b1);
      check("t3_new_addr", ibus_if.addr, 32'h0000_0200);
      ibus_if.ack = 1'b1; tick();
      ibus_if.ack = 1'b0; ibus_if.rvalid = 1'b1; ibus_if.rdata = 32'h1111_1111; tick();
      ibus_if.rvalid = 1'b0; i_en = 1'b0; settle();
      check("t3_valid", inst_valid, 1'b1);
      check("t3_inst", inst, 32'h1111_1111);
      check("t3_inst_pc", inst_pc, 32'h0000_0200);
      tick();

      // Flush while waiting for data
      pc = 32'h0000_0300; i_en = 1'b1; ibus_if.ack = 1'b1; tick();
      ibus_if.ack = 1'b0; flush = 1'b1; tick();
      flush = 1'b0; pc = 32'h0000_0400;
      ibus_if.rvalid = 1'b1; ibus_if.rdata = 32'hBAD0_BAD0; settle();
      check("t4_kwait_req", ibus_if.req, 1'b0);
      check("t4_kwait_stall", if_stall, 1'b1);
      tick();
      ibus_if.rvalid = 1'b0; settle();
      check("t4_dropped", inst_valid, 1'b0);
      check("t4_idle_req", ibus_if.req, 1'b1);
      check("t4_idle_addr", ibus_if.addr, 32'h0000_0400);
      ibus_if.ack = 1'b1; tick();
      ibus_if.ack = 1'b0; ibus_if.rvalid = 1'b1; ibus_if.rdata = 32'h2222_2222; tick();
      ibus_if.rvalid = 1'b0; i_en = 1'b0; settle();
      check("t4_inst", inst, 32'h2222_2222);
      check("t4_inst_pc", inst_pc, 32'h0000_0400);
      tick();

      // Decode stalled when the response arrives
      pc = 32'h0000_0500; i_en = 1'b1; ibus_if.ack = 1'b1; tick();
      ibus_if.ack = 1'b0; ibus_if.rvalid = 1'b1; ibus_if.rdata = 32'h0000_000C;
      stall_in = 1'b1; settle();
`ifdef IF_HOLD_BUF_EN
      check("t5_stall_cap", if_stall, 1'b0);
      tick();
      ibus_if.rvalid = 1'b0; pc = 32'h0000_0504;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("t5_hold_req", ibus_if.req, 1'b0);
         check("t5_hold_stall", if_stall, 1'b1);
         check("t5_hold_valid", inst_valid, 1'b0);
         tick();
      end
      stall_in = 1'b0; settle();
      check("t5_rel_stall", if_stall, 1'b1);
      tick();
      i_en = 1'b0; settle();
      check("t5_valid", inst_valid, 1'b1);
      check("t5_inst", inst, 32'h0000_000C);
      check("t5_inst_pc", inst_pc, 32'h0000_0500);
      tick();
`else
      check("t5_stall_drop", if_stall, 1'b1);
      tick();
      ibus_if.rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("t5_idle_req", ibus_if.req, 1'b0);
         check("t5_idle_stall", if_stall, 1'b1);
         check("t5_idle_valid", inst_valid, 1'b0);
         tick();
      end
      stall_in = 1'b0; settle();
      check("t5_rereq", ibus_if.req, 1'b1);
      check("t5_rereq_addr", ibus_if.addr, 32'h0000_0500);
      ibus_if.ack = 1'b1; tick();
      ibus_if.ack = 1'b0; ibus_if.rvalid = 1'b1; tick();
      ibus_if.rvalid = 1'b0; i_en = 1'b0; settle();
      check("t5_valid", inst_valid, 1'b1);
      check("t5_inst", inst, 32'h0000_000C);
      check("t5_inst_pc", inst_pc, 32'h0000_0500);
      tick();
`endif

      // Ack withheld for five cycles
      pc = 32'h0000_0600; i_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         check("t6_req", ibus_if.req, 1'b1);
         check("t6_addr", ibus_if.addr, 32'h0000_0600);
         check("t6_stall", if_stall, 1'b1);
         tick();
      end
      ibus_if.ack = 1'b1; tick();
      ibus_if.ack = 1'b0; ibus_if.rvalid = 1'b1; ibus_if.rdata = 32'h3333_3333; tick();
      ibus_if.rvalid = 1'b0; i_en = 1'b0; settle();
      check("t6_inst", inst, 32'h3333_3333);
      check("t6_inst_pc", inst_pc, 32'h0000_0600);
      tick();

      // Reset in the middle of a transaction
      pc = 32'h0000_0700; i_en = 1'b1; ibus_if.ack = 1'b1; tick();
      ibus_if.ack = 1'b0; rst = 1'b0; settle();
      check("t7_req_rst", ibus_if.req, 1'b0);
      check("t7_valid_rst", inst_valid, 1'b0);
      tick();
      rst = 1'b1; settle();
      check("t7_idle_req", ibus_if.req, 1'b1);
      check("t7_idle_addr", ibus_if.addr, 32'h0000_0700);
      ibus_if.ack = 1'b1; tick();
      ibus_if.ack = 1'b0; ibus_if.rvalid = 1'b1; ibus_if.rdata = 32'h4444_4444; tick();
      ibus_if.rvalid = 1'b0; i_en = 1'b0; settle();
      check("t7_inst", inst, 32'h4444_4444);
      check("t7_inst_pc", inst_pc, 32'h0000_0700);
      tick();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
